positadd_stream_ctrl: RTL

POSITADD_STREAM_CTRL -- requirements
Module: positadd_stream_ctrl

---
 rtl/positadd_stream_ctrl_if.sv | 41 ++++
 rtl/positadd_stream_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/positadd_stream_ctrl_if.sv
// Handshake bundle for positadd_stream_ctrl: upstream operand stream, adder
// operand/result bus, downstream result stream and status.
interface positadd_stream_ctrl_if #(
  parameter int N     = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          s_valid;
  logic          s_ready;
  logic [N-1:0]  s_in1;
  logic [N-1:0]  s_in2;

  logic [N-1:0]  add_in1;
  logic [N-1:0]  add_in2;
  logic          add_start;
  logic [N-1:0]  add_result;
  logic          add_inf;
  logic          add_zero;

  logic          m_valid;
  logic          m_ready;
  logic [N-1:0]  m_result;
  logic          m_inf;
  logic          m_zero;

  logic [CW-1:0] credits_used;
  logic          ovf_err;

  modport slave (
    input  s_valid, s_in1, s_in2, add_result, add_inf, add_zero, m_ready,
    output s_ready, add_in1, add_in2, add_start, m_valid, m_result, m_inf, m_zero,
           credits_used, ovf_err
  );

  modport master (
    output s_valid, s_in1, s_in2, add_result, add_inf, add_zero, m_ready,
    input  s_ready, add_in1, add_in2, add_start, m_valid, m_result, m_inf, m_zero,
           credits_used, ovf_err
  );
endinterface

// File: rtl/positadd_stream_ctrl.sv
// Credit-based stream wrapper around a fixed-latency posit adder: issues
// operand pairs, tracks them with a valid shift register, queues results in a FWFT FIFO.
module positadd_stream_ctrl #(
  parameter int N       = 32,
  parameter int LATENCY = 8,
  parameter int DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  positadd_stream_ctrl_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = N + 2;

  logic [CW-1:0]      credits_reg;
  logic [AW:0]        wr_ptr_reg;
  logic [AW:0]        rd_ptr_reg;
  logic [LATENCY-1:0] vsr_reg;
  logic [N-1:0]       in1_reg;
  logic [N-1:0]       in2_reg;
  logic               start_reg;
  logic               ovf_reg;
  logic [W-1:0]       mem [DEPTH];

  logic               issue;
  logic               pop;
  logic               empty;
  logic               full;
  logic               wr_req;
  logic               wr_en;
  logic [W-1:0]       head;

  // Credits count both in-flight ops and queued results, so an accepted
  // operand always has a FIFO slot waiting for it.
  assign io.s_ready = (credits_reg < CW'(DEPTH));
  assign issue      = io.s_valid & io.s_ready;

  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop    = ~empty & io.m_ready;
  assign wr_req = vsr_reg[LATENCY-1];
  assign wr_en  = wr_req & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      vsr_reg     <= '0;
      in1_reg     <= '0;
      in2_reg     <= '0;
      start_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      start_reg <= issue;
      if (issue) begin
        in1_reg <= io.s_in1;
        in2_reg <= io.s_in2;
      end
      // Bit k is set k+1 cycles after add_start, so the MSB lines up with add_result.
      vsr_reg <= (vsr_reg << 1) | LATENCY'(start_reg);

      case ({issue, pop})
        2'b10:   credits_reg <= credits_reg + CW'(1);
        2'b01:   credits_reg <= credits_reg - CW'(1);
        default: credits_reg <= credits_reg;
      endcase

      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_req && !wr_en) ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= {io.add_result, io.add_inf, io.add_zero};
  end

  assign head            = mem[rd_ptr_reg[AW-1:0]];
  assign io.m_valid      = ~empty;
  assign io.m_result     = head[W-1:2];
  assign io.m_inf        = head[1];
  assign io.m_zero       = head[0];
  assign io.add_in1      = in1_reg;
  assign io.add_in2      = in2_reg;
  assign io.add_start    = start_reg;
  assign io.credits_used = credits_reg;
  assign io.ovf_err      = ovf_reg;
endmodule
